// File: rtl/serial_adder_seq_pkg.sv
// Shared types and limits for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

  localparam int SA_WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-position counter width; clamped to the supported operand range.
  function automatic int cnt_width(input int w);
    int c;
    c = (w > SA_WIDTH_MAX) ? SA_WIDTH_MAX : w;
    return (c < 2) ? 1 : $clog2(c);
  endfunction

endpackage

// File: rtl/serial_adder_seq_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// Latency: n/a (wires only).
// Backpressure: in_ready/out_ready carry the valid-ready flow control.
interface serial_adder_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Producer/consumer side driving operands and taking results.
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/serial_adder_seq_fa_cell.sv
// One-bit full adder: sum is the XOR of the inputs, carry is their majority.
// Latency: combinational.
// Backpressure: none.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Pure combinational cell; the carry loop is closed by the caller's flop.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial a+b+cin, LSB first, one bit position per clock through fa_cell.
// Latency: accept edge t, result valid after edge t+WIDTH, drained on edge t+WIDTH+1 earliest.
// Backpressure: in_ready low while busy; result and carry held in DONE until out_ready.
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_adder_seq_if.slave bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             fa_s;
  logic             fa_co;

  // The only arithmetic: one bit position per cycle, carry fed back via the carry flop.
  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Control FSM plus datapath registers; handshake outputs are registered alongside state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr       <= bus.a;
            b_sr       <= bus.b;
            carry      <= bus.cin;
            sum_sr     <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // Sum bits enter at the MSB so bit i lands at position i after WIDTH steps.
          sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
          carry  <= fa_co;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          if (cnt == LAST) begin
            // Exact terminal compare; the counter parks instead of wrapping.
            cnt         <= '0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Result ports are straight register outputs; meaningful only while out_valid.
  always_comb begin
    bus.in_ready  = in_ready_r;
    bus.out_valid = out_valid_r;
    bus.sum       = sum_sr;
    bus.cout      = carry;
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Randomized and directed checks of serial_adder_seq at WIDTH=8 and WIDTH=3.
// Reference model: {cout,sum} = a + b + cin in plain integer arithmetic.
// Outputs sampled on the falling edge; inputs driven there too.
module tb_serial_adder_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  serial_adder_seq_if #(.WIDTH(8)) bus8 ();
  serial_adder_seq_if #(.WIDTH(3)) bus3 ();

  serial_adder_seq #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder_seq #(.WIDTH(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int unsigned t;
    t = int'(a) + int'(b) + int'(cin);
    return t[8:0];
  endfunction

  function automatic logic [3:0] ref3(input logic [2:0] a, input logic [2:0] b, input logic cin);
    int unsigned t;
    t = int'(a) + int'(b) + int'(cin);
    return t[3:0];
  endfunction

  // One WIDTH=8 operation. hold: cycles of out_ready=0 after out_valid rises.
  // poke: pulse in_valid with a=0x11 during the shift phase.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input int hold, input bit poke);
    int          k;
    logic [8:0]  exp;
    logic [8:0]  held;
    exp = ref8(a, b, cin);
    bus8.a = a; bus8.b = b; bus8.cin = cin;
    bus8.out_ready = (hold == 0);
    bus8.in_valid = 1'b1;
    chk({tag, ".in_ready_pre"}, 64'(bus8.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    k = 0;
    while (!bus8.out_valid && k < 40) begin
      chk({tag, ".in_ready_busy"}, 64'(bus8.in_ready), 64'd0);
      if (poke && k == 2) begin
        bus8.a = 8'h11; bus8.in_valid = 1'b1;
      end else begin
        bus8.in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    bus8.in_valid = 1'b0;
    chk({tag, ".latency"}, 64'(k), 64'd8);
    chk({tag, ".result"}, 64'({bus8.cout, bus8.sum}), 64'(exp));
    held = {bus8.cout, bus8.sum};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".hold_valid"}, 64'(bus8.out_valid), 64'd1);
      chk({tag, ".hold_result"}, 64'({bus8.cout, bus8.sum}), 64'(held));
      chk({tag, ".hold_in_ready"}, 64'(bus8.in_ready), 64'd0);
    end
    bus8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".drained"}, 64'(bus8.out_valid), 64'd0);
    chk({tag, ".in_ready_post"}, 64'(bus8.in_ready), 64'd1);
  endtask

  task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic cin);
    int k;
    bus3.a = a; bus3.b = b; bus3.cin = cin;
    bus3.out_ready = 1'b1;
    bus3.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus3.in_valid = 1'b0;
    k = 0;
    while (!bus3.out_valid && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    if (k != 3) chk("w3.latency", 64'(k), 64'd3);
    chk($sformatf("w3.%0d+%0d+%0d", a, b, cin), 64'({bus3.cout, bus3.sum}), 64'(ref3(a, b, cin)));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int k;
    logic [7:0] ra;
    logic [7:0] rb;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;
    bus3.in_valid = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0; bus3.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", 64'(bus8.in_ready), 64'd1);
    chk("rst.out_valid", 64'(bus8.out_valid), 64'd0);
    chk("rst.result", 64'({bus8.cout, bus8.sum}), 64'd0);
    chk("rst3.in_ready", 64'(bus3.in_ready), 64'd1);
    rst_n = 1'b1;

    run8("t5a3c", 8'h5A, 8'h3C, 1'b0, 0, 1'b0);
    run8("tff01", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run8("tffff", 8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    run8("thold", 8'hA7, 8'h6E, 1'b1, 5, 1'b0);
    run8("tpoke", 8'h22, 8'h22, 1'b0, 0, 1'b1);

    // Reset after three shift edges discards the in-flight operation.
    bus8.a = 8'hC3; bus8.b = 8'h5F; bus8.cin = 1'b1; bus8.out_ready = 1'b1;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(bus8.out_valid), 64'd0);
    chk("midrst.in_ready", 64'(bus8.in_ready), 64'd1);
    chk("midrst.sum", 64'(bus8.sum), 64'd0);
    chk("midrst.cout", 64'(bus8.cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // No stale result may surface after reset while idle.
    k = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.out_valid) k++;
    end
    chk("midrst.no_result", 64'(k), 64'd0);
    run8("tpost", 8'h03, 8'h04, 1'b0, 0, 1'b0);

    // Randomized operands with random back-pressure.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run8($sformatf("rnd%0d", i), ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    // WIDTH=3 exhaustive.
    for (int ai = 0; ai < 8; ai++)
      for (int bi = 0; bi < 8; bi++)
        for (int ci = 0; ci < 2; ci++)
          run3(3'(ai), 3'(bi), 1'(ci));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
